siso_shift_ctrl: RTL and testbench

Controller that shares one WIDTH-bit serial shift path between two parallel-word requesters. It round-robin arbitrates between the requesters and accepts one word through a valid/ready handshake. It then serializes the word LSB-first with a frame strobe and inserts a programmable idle gap before the next word. It sits in front of the serial shift-register chain and is the only writer of its serial input.

---
 rtl/siso_shift_ctrl_pkg.sv | 23 ++
 rtl/siso_shift_ctrl_piso.sv | 38 +++
 rtl/siso_shift_ctrl.sv | 130 +++++++++++++
 tb/tb_siso_shift_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_shift_ctrl_pkg.sv
// Shared types for the two-requester serial shift controller.
// State encoding, default sizing and requester ids.
package siso_shift_ctrl_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_GAP_CYCLES = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/siso_shift_ctrl_piso.sv
// Parallel-load, shift-right register feeding the serial path.
// Zeros enter at the MSB; bit 0 is the serial tap.
module piso_shift_reg
    import siso_shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q0
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = d;
        end else if (shift) begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q0 = sr_q[0];

endmodule

// File: rtl/siso_shift_ctrl.sv
// Round-robin front end for a shared serial shift chain.
// Accepts one word, sends it LSB-first under frame, then idles.
module siso_shift_ctrl
    import siso_shift_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             serial_out,
    output logic             frame,
    output logic             busy,
    output req_id_t          grant_id
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e          state_q;
    logic [CW-1:0]   bit_q;
    logic [GW-1:0]   gap_q;
    req_id_t         grant_q;
    req_id_t         ptr_q;
    logic            frame_q;
    logic            busy_q;

    logic            gnt0;
    logic            gnt1;
    logic            idle;
    logic            accept;
    logic            shift_en;
    logic            q0;
    req_id_t         win;
    logic [WIDTH-1:0] win_data;

    // ptr_q names the requester that wins a tie.
    assign gnt0 = req0_valid && (!req1_valid || ptr_q == REQ0);
    assign gnt1 = req1_valid && (!req0_valid || ptr_q == REQ1);

    assign idle       = (state_q == ST_IDLE);
    assign req0_ready = idle && gnt0;
    assign req1_ready = idle && gnt1;
    assign accept     = req0_ready || req1_ready;
    assign win        = gnt1 ? REQ1 : REQ0;
    assign win_data   = gnt1 ? req1_data : req0_data;
    assign shift_en   = (state_q == ST_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            gap_q   <= '0;
            grant_q <= REQ0;
            ptr_q   <= REQ0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_SHIFT;
                        bit_q   <= '0;
                        grant_q <= win;
                        ptr_q   <= other_req(win);
                        frame_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bit_q == BIT_LAST) begin
                        bit_q   <= '0;
                        frame_q <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_GAP;
                            gap_q   <= '0;
                        end
                    end else begin
                        bit_q <= bit_q + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                        gap_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    frame_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (shift_en),
        .d     (win_data),
        .q0    (q0)
    );

    // Gated by frame so the line sits at 0 outside data bits and in reset.
    assign serial_out = frame_q & q0;
    assign frame      = frame_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Scoreboard bench for siso_shift_ctrl: W=8/GAP=1 and W=2/GAP=0.
// Random requester traffic checked against a cycle-count model.
module tb_siso_shift_ctrl;

    typedef struct {
        int unsigned dly;
        logic [7:0]  data;
    } stim_t;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         start;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit done_f [2];

    task automatic chk(input string nm, input longint a, input longint e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, a, e);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int W = (k == 0) ? 8 : 2;
        localparam int G = (k == 0) ? 1 : 0;

        logic         rst_n;
        logic         v0, v1, r0, r1;
        logic [W-1:0] d0, d1;
        logic         so, fr, bz, gid;
        logic         rdy_s [2];

        stim_t sq [2][$];
        exp_t  expq [$];

        int   cyc       = 0;
        int   free_at   = 0;
        int   busy_from = 0;
        int   last      = 1;
        bit   chk_en    = 0;
        bit   inf       = 0;
        bit   post      = 0;
        bit   served    = 0;
        int   idx       = 0;
        exp_t cur;
        bit   act_f [2];
        bit   have_f [2];

        siso_shift_ctrl #(
            .WIDTH      (W),
            .GAP_CYCLES (G)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req0_valid (v0),
            .req0_data  (d0),
            .req0_ready (r0),
            .req1_valid (v1),
            .req1_data  (d1),
            .req1_ready (r1),
            .serial_out (so),
            .frame      (fr),
            .busy       (bz),
            .grant_id   (gid)
        );

        task automatic ck(input string nm, input longint a, input longint e);
            chk($sformatf("i%0d_%s", k, nm), a, e);
        endtask

        task automatic drive(input int j, input logic v, input logic [W-1:0] d);
            if (j == 0) begin
                v0 = v;
                d0 = d;
            end else begin
                v1 = v;
                d1 = d;
            end
        endtask

        task automatic run_drv(input int j);
            stim_t s;
            bit act  = 0;
            bit have = 0;
            bit hs;
            int tmo  = 0;
            forever begin
                @(posedge clk);
                hs = act && rdy_s[j];
                #1;
                if (!rst_n) begin
                    act  = 0;
                    have = 0;
                    drive(j, 1'b0, '0);
                end else begin
                    if (hs) begin
                        act = 0;
                        drive(j, 1'b0, '0);
                    end
                    if (!act) begin
                        if (!have && sq[j].size() > 0) begin
                            s    = sq[j].pop_front();
                            have = 1;
                        end
                        if (have) begin
                            if (s.dly == 0) begin
                                have = 0;
                                act  = 1;
                                tmo  = 0;
                                drive(j, 1'b1, s.data[W-1:0]);
                            end else begin
                                s.dly--;
                            end
                        end
                    end else begin
                        tmo++;
                        if (tmo > 400) begin
                            ck($sformatf("req%0d_accept_timeout", j), tmo, 0);
                            act = 0;
                            drive(j, 1'b0, '0);
                        end
                    end
                end
                act_f[j]  = act;
                have_f[j] = have;
            end
        endtask

        initial run_drv(0);
        initial run_drv(1);

        initial forever begin
            @(posedge clk);
            cyc++;
        end

        // Reference: one word per W+G+1 cycles, tie goes to the other requester.
        initial begin : model
            int         gi;
            bit         gv;
            logic [7:0] gd;
            forever begin
                @(negedge clk);
                rdy_s[0] = r0;
                rdy_s[1] = r1;
                if (chk_en) begin
                    gv = 0;
                    gi = 0;
                    if (cyc >= free_at && (v0 || v1)) begin
                        gv = 1;
                        gi = (v0 && v1) ? 1 - last : (v0 ? 0 : 1);
                        gd = (gi == 0) ? 8'(d0) : 8'(d1);
                        expq.push_back('{gi, gd, cyc + 1});
                        last      = gi;
                        busy_from = cyc + 1;
                        free_at   = cyc + W + G + 1;
                    end
                    ck("ready0", r0, gv && gi == 0);
                    ck("ready1", r1, gv && gi == 1);
                    ck("busy", bz, cyc >= busy_from && cyc < free_at);
                end
            end
        end

        initial begin : mon
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    if (post) begin
                        post = 0;
                        ck("frame_end", fr, 0);
                    end
                    if (fr) begin
                        if (!inf) begin
                            if (expq.size() == 0) begin
                                ck("unexpected_frame", fr, 0);
                            end else begin
                                cur    = expq.pop_front();
                                inf    = 1;
                                idx    = 0;
                                served = 1;
                                ck("frame_start", cyc, cur.start);
                                ck("grant_id", gid, cur.id);
                            end
                        end
                        if (inf) begin
                            ck($sformatf("bit%0d", idx), so, cur.data[idx]);
                            idx++;
                            if (idx == W) begin
                                inf  = 0;
                                post = 1;
                            end
                        end
                    end else begin
                        if (inf) begin
                            ck("frame_short", idx, W);
                            inf = 0;
                        end
                        ck("serial_idle", so, 0);
                        if (served) ck("grant_hold", gid, cur.id);
                    end
                end
            end
        end

        task automatic drain();
            int n = 0;
            while ((sq[0].size() != 0 || sq[1].size() != 0 ||
                    act_f[0] || act_f[1] || have_f[0] || have_f[1] ||
                    expq.size() != 0 || inf || post || cyc <= free_at) &&
                   n < 5000) begin
                @(posedge clk);
                n++;
            end
            if (n >= 5000) ck("drain_timeout", n, 0);
            repeat (2) @(posedge clk);
        endtask

        initial begin : seq
            int n;
            v0 = 0;
            v1 = 0;
            d0 = '0;
            d1 = '0;
            rdy_s[0] = 0;
            rdy_s[1] = 0;
            rst_n = 0;
            repeat (3) @(posedge clk);
            #1;
            ck("rst_frame", fr, 0);
            ck("rst_serial", so, 0);
            ck("rst_busy", bz, 0);
            ck("rst_gid", gid, 0);
            ck("rst_rdy0", r0, 0);
            ck("rst_rdy1", r1, 0);
            rst_n  = 1;
            chk_en = 1;
            repeat (4) @(posedge clk);
            if (k == 0) begin
                #3;
                sq[0].push_back('{0, 8'h0F});
                sq[0].push_back('{0, 8'h0F});
                sq[1].push_back('{0, 8'hF0});
                sq[1].push_back('{0, 8'hF0});
                drain();
                #3;
                sq[0].push_back('{0, 8'hA5});
                sq[0].push_back('{0, 8'h3C});
                drain();
                #3;
                sq[0].push_back('{0, 8'h81});
                sq[1].push_back('{3, 8'h7E});
                drain();
                #3;
                for (int i = 0; i < 40; i++) begin
                    sq[0].push_back('{$urandom_range(0, 12), 8'($urandom)});
                    sq[1].push_back('{$urandom_range(0, 12), 8'($urandom)});
                end
                drain();
                #3;
                sq[1].push_back('{0, 8'hFF});
                n = 0;
                while (!fr && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                ck("mid_frame_seen", fr, 1);
                repeat (3) @(posedge clk);
                #2;
                ck("mid_frame_serial", so, 1);
                chk_en = 0;
                rst_n  = 0;
                #1;
                ck("arst_frame", fr, 0);
                ck("arst_serial", so, 0);
                ck("arst_busy", bz, 0);
                ck("arst_gid", gid, 0);
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1;
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    ck("no_replay", fr, 0);
                end
            end else begin
                #3;
                sq[1].push_back('{0, 8'h02});
                sq[1].push_back('{0, 8'h01});
                sq[1].push_back('{0, 8'h03});
                sq[1].push_back('{0, 8'h02});
                drain();
                #3;
                for (int i = 0; i < 30; i++) begin
                    sq[0].push_back('{$urandom_range(0, 6), 8'($urandom)});
                    sq[1].push_back('{$urandom_range(0, 6), 8'($urandom)});
                end
                drain();
                chk_en = 0;
            end
            done_f[k] = 1;
        end
    end

    initial begin : top
        int n = 0;
        while (!(done_f[0] && done_f[1]) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 60000) chk("global_timeout", n, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
